// File: rtl/branch_resolve_queue.sv
// ============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order queue of predicted branches. It checks the head entry
//            at execute, then drives predictor training plus flush/redirect.
//            Optional macro BRANCH_STATS_EN builds the resolve and
//            mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_valid,
    input  logic [ADDR_WIDTH-1:0]     fetch_pc,
    input  logic                      fetch_pred,
    input  logic [ADDR_WIDTH-1:0]     fetch_target,
    output logic                      fetch_ready,
    input  logic                      ex_valid,
    input  logic                      ex_taken,
    input  logic [ADDR_WIDTH-1:0]     ex_target,
    input  logic                      ext_flush,
    output logic                      upd_valid,
    output logic                      upd_taken,
    output logic                      mispredict,
    output logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      err_underflow,
    output logic [31:0]               stat_resolved,
    output logic [31:0]               stat_mispredict
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_tgt  [DEPTH];
    logic                  r_pred [DEPTH];

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic                  r_upd_valid;
    logic                  r_upd_taken;
    logic                  r_mispredict;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;
    logic                  r_err_underflow;

    logic [PW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_resolve;
    logic                  w_mis;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [ADDR_WIDTH-1:0] w_head_tgt;
    logic                  w_head_pred;

    // The pointers carry one extra wrap bit, so their difference is the
    // entry count even when both sit on the same slot.
    assign w_count     = r_wptr - r_rptr;
    assign w_full      = (w_count == PW'(DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_push      = fetch_valid && !w_full;
    assign w_resolve   = ex_valid && !w_empty && !ext_flush;

    assign w_head_pc   = r_pc[r_rptr[IW-1:0]];
    assign w_head_tgt  = r_tgt[r_rptr[IW-1:0]];
    assign w_head_pred = r_pred[r_rptr[IW-1:0]];

    assign w_mis = w_resolve &&
                   ((w_head_pred != ex_taken) ||
                    (w_head_pred && ex_taken && (w_head_tgt != ex_target)));

    // The payload needs no reset. A write that is discarded by a same-cycle
    // clear lands in a slot that is unreachable until it is rewritten.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr[IW-1:0]]   <= fetch_pc;
            r_tgt[r_wptr[IW-1:0]]  <= fetch_target;
            r_pred[r_wptr[IW-1:0]] <= fetch_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_upd_valid     <= 1'b0;
            r_upd_taken     <= 1'b0;
            r_mispredict    <= 1'b0;
            r_redirect_pc   <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_upd_valid  <= w_resolve;
            r_upd_taken  <= w_resolve && ex_taken;
            r_mispredict <= w_mis;
            if (w_mis) begin
                r_redirect_pc <= ex_taken ? ex_target
                                          : (w_head_pc + ADDR_WIDTH'(4));
            end
            if (ex_valid && w_empty && !ext_flush) begin
                r_err_underflow <= 1'b1;
            end
            if (ext_flush || w_mis) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_resolve) begin
                    r_rptr <= r_rptr + PW'(1);
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else begin
            if (w_resolve && (r_stat_resolved != 32'hFFFF_FFFF)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_mis && (r_stat_mispredict != 32'hFFFF_FFFF)) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`else
    assign stat_resolved   = 32'd0;
    assign stat_mispredict = 32'd0;
`endif

    assign fetch_ready   = !w_full;
    assign occupancy     = w_count;
    assign upd_valid     = r_upd_valid;
    assign upd_taken     = r_upd_taken;
    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirect_pc;
    assign err_underflow = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Directed self-checking bench for branch_resolve_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   fetch_valid;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic                   fetch_pred;
    logic [ADDR_WIDTH-1:0]  fetch_target;
    logic                   fetch_ready;
    logic                   ex_valid;
    logic                   ex_taken;
    logic [ADDR_WIDTH-1:0]  ex_target;
    logic                   ext_flush;
    logic                   upd_valid;
    logic                   upd_taken;
    logic                   mispredict;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   err_underflow;
    logic [31:0]            stat_resolved;
    logic [31:0]            stat_mispredict;

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolve_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_pred      (fetch_pred),
        .fetch_target    (fetch_target),
        .fetch_ready     (fetch_ready),
        .ex_valid        (ex_valid),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ext_flush       (ext_flush),
        .upd_valid       (upd_valid),
        .upd_taken       (upd_taken),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .occupancy       (occupancy),
        .err_underflow   (err_underflow),
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_pred   = pred;
        fetch_target = tgt;
        tick();
        fetch_valid  = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_taken  = taken;
        ex_target = tgt;
        tick();
        ex_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_pred = 1'b0;
        fetch_target = '0; ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
        ext_flush = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_occ",      32'(occupancy),     32'd0);
        check("rst_ready",    32'(fetch_ready),   32'd1);
        check("rst_upd",      32'(upd_valid),     32'd0);
        check("rst_mis",      32'(mispredict),    32'd0);
        check("rst_redirect", redirect_pc,        32'h0);
        check("rst_err",      32'(err_underflow), 32'd0);

        // Correct not-taken prediction
        push(32'h100, 1'b0, 32'h0);
        check("t1_occ_push", 32'(occupancy), 32'd1);
        resolve(1'b0, 32'h0);
        check("t1_upd",   32'(upd_valid),  32'd1);
        check("t1_taken", 32'(upd_taken),  32'd0);
        check("t1_mis",   32'(mispredict), 32'd0);
        check("t1_occ",   32'(occupancy),  32'd0);
        tick();
        check("t1_upd_pulse", 32'(upd_valid), 32'd0);

        // Predicted not-taken, actually taken
        push(32'h200, 1'b0, 32'h0);
        resolve(1'b1, 32'h300);
        check("t2_mis",      32'(mispredict), 32'd1);
        check("t2_redirect", redirect_pc,     32'h300);
        check("t2_taken",    32'(upd_taken),  32'd1);
        check("t2_occ",      32'(occupancy),  32'd0);
        tick();
        check("t2_mis_pulse", 32'(mispredict), 32'd0);
        check("t2_hold",      redirect_pc,     32'h300);

        // Taken, wrong target
        push(32'h400, 1'b1, 32'h500);
        resolve(1'b1, 32'h504);
        check("t3_mis",      32'(mispredict), 32'd1);
        check("t3_redirect", redirect_pc,     32'h504);

        // Predicted taken, actually not taken -> fall through to pc+4
        push(32'h600, 1'b1, 32'h700);
        resolve(1'b0, 32'h0);
        check("t4_mis",      32'(mispredict), 32'd1);
        check("t4_redirect", redirect_pc,     32'h604);
        check("t4_taken",    32'(upd_taken),  32'd0);

        // Fill the queue
        push(32'h1000, 1'b1, 32'h2000);
        push(32'h1010, 1'b0, 32'h0);
        push(32'h1020, 1'b1, 32'h3000);
        push(32'h1030, 1'b0, 32'h0);
        check("fill_occ",   32'(occupancy),   32'd4);
        check("fill_ready", 32'(fetch_ready), 32'd0);

        // Push while full is refused even with a same-cycle correct resolve
        fetch_valid = 1'b1; fetch_pc = 32'h1040; fetch_pred = 1'b0; fetch_target = '0;
        ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h2000;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b0;
        check("full_occ",   32'(occupancy),   32'd3);
        check("full_ready", 32'(fetch_ready), 32'd1);
        check("full_mis",   32'(mispredict),  32'd0);
        check("full_upd",   32'(upd_taken),   32'd1);

        // Simultaneous push + correct resolve of head 0x1010
        fetch_valid = 1'b1; fetch_pc = 32'h1040; fetch_pred = 1'b0;
        ex_valid = 1'b1; ex_taken = 1'b0;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b0;
        check("pr_occ", 32'(occupancy), 32'd3);
        check("pr_mis", 32'(mispredict), 32'd0);

        push(32'h1050, 1'b1, 32'h4000);
        check("fill2_occ", 32'(occupancy), 32'd4);
        resolve(1'b1, 32'h3000);
        check("r2_mis", 32'(mispredict), 32'd0);
        check("r2_occ", 32'(occupancy),  32'd3);

        // Head 0x1030 predicted not-taken but taken; same-cycle push discarded
        fetch_valid = 1'b1; fetch_pc = 32'h1060; fetch_pred = 1'b0;
        ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h9000;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b0;
        check("fm_mis",      32'(mispredict), 32'd1);
        check("fm_redirect", redirect_pc,     32'h9000);
        check("fm_occ",      32'(occupancy),  32'd0);

        // Resolve on empty queue
        resolve(1'b1, 32'h1234);
        check("uf_err", 32'(err_underflow), 32'd1);
        check("uf_upd", 32'(upd_valid),     32'd0);
        check("uf_mis", 32'(mispredict),    32'd0);
        tick(); tick();
        check("uf_sticky", 32'(err_underflow), 32'd1);

        // External flush with two entries, resolve and push in the same cycle
        push(32'h5000, 1'b0, 32'h0);
        push(32'h5010, 1'b0, 32'h0);
        check("xf_pre_occ", 32'(occupancy), 32'd2);
        ext_flush = 1'b1; ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h7777;
        fetch_valid = 1'b1; fetch_pc = 32'h5020;
        tick();
        ext_flush = 1'b0; ex_valid = 1'b0; fetch_valid = 1'b0;
        check("xf_occ",      32'(occupancy),  32'd0);
        check("xf_upd",      32'(upd_valid),  32'd0);
        check("xf_mis",      32'(mispredict), 32'd0);
        check("xf_redirect", redirect_pc,     32'h9000);

`ifdef BRANCH_STATS_EN
        check("stat_resolved",   stat_resolved,   32'd8);
        check("stat_mispredict", stat_mispredict, 32'd4);
`else
        check("stat_resolved_off",   stat_resolved,   32'd0);
        check("stat_mispredict_off", stat_mispredict, 32'd0);
`endif

        // Mid-operation reset
        push(32'h6000, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_occ",      32'(occupancy),     32'd0);
        check("mr_err",      32'(err_underflow), 32'd0);
        check("mr_redirect", redirect_pc,        32'h0);
        check("mr_ready",    32'(fetch_ready),   32'd1);
        check("mr_stat",     stat_resolved,      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every in-flight predicted branch from fetch to execute, in order.
- At execute, checks the head entry's prediction against the actual outcome and target.
- Drives the 2-bit predictor's update pair (branch_valid, branch_taken), plus flush and redirect PC on a mispredict.
- Sits directly downstream of the predictor. It consumes `prediction` at fetch and feeds training back to it.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of 2, ≥2)
ADDR_WIDTH, 32, PC/target width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch pushes a predicted-branch record
fetch_pc  in  ADDR_WIDTH  PC of the branch
fetch_pred  in  1  predictor output at fetch (1 = taken)
fetch_target  in  ADDR_WIDTH  predicted target (used when fetch_pred = 1)
fetch_ready  out  1  queue accepts a push this cycle
ex_valid  in  1  execute resolves the oldest branch
ex_taken  in  1  actual outcome
ex_target  in  ADDR_WIDTH  actual taken target
ext_flush  in  1  external flush (jump/trap); discards all entries
upd_valid  out  1  to predictor branch_valid
upd_taken  out  1  to predictor branch_taken
mispredict  out  1  pipeline flush request
redirect_pc  out  ADDR_WIDTH  corrected fetch PC, valid while mispredict = 1
occupancy  out  $clog2(DEPTH)+1  current entry count
err_underflow  out  1  sticky: ex_valid arrived with queue empty
stat_resolved  out  32  resolved branch count
stat_mispredict  out  32  mispredict count

Behaviour:
Storage and handshake:
- Circular buffer of {pc, pred, target}.
- Read/write pointers are $clog2(DEPTH)+1 bits wide; wrap modulo 2·DEPTH.
- full = (occupancy == DEPTH); empty = (occupancy == 0).
- fetch_ready = !full. It depends on count only; a same-cycle pop does not free a slot.
- Push = fetch_valid && fetch_ready.
- Resolve = ex_valid && !empty && !ext_flush, using the head entry as it stood at cycle start. A same-cycle push is never bypassed to resolve.

Mispredict condition (head entry):
- (pred != ex_taken), or
- (pred && ex_taken && target != ex_target).

Registered outputs (1-cycle latency after the resolve edge):
- upd_valid = 1 and upd_taken = ex_taken for exactly one cycle per resolve.
- On mispredict: mispredict = 1 for one cycle.
  - redirect_pc = ex_target if ex_taken.
  - redirect_pc = pc + 4 (modulo 2^ADDR_WIDTH) otherwise.
- Otherwise mispredict = 0 and redirect_pc holds its last value.

Queue clears:
- A resolve that mispredicts clears the queue at that edge (both pointers to 0, occupancy 0).
- A push in that same cycle is discarded.

ext_flush:
- Clears the queue at that edge and discards any same-cycle push.
- Suppresses resolution: no upd_valid, no mispredict, stats unchanged.

Empty-queue resolve:
- ex_valid with empty (and no ext_flush) sets err_underflow.
- err_underflow stays set until reset; it produces no update.

Simultaneous push + resolve when not full and correctly predicted: occupancy unchanged, both pointers advance.

Reset (synchronous, any cycle, including mid-operation) clears:
- pointers, occupancy, upd_valid, upd_taken, mispredict, err_underflow, stat counters;
- redirect_pc to 0.
Entry payload need not reset. fetch_ready = 1 after reset.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - stat_resolved increments on every resolve.
  - stat_mispredict increments on every mispredicting resolve.
  - Both saturate at 0xFFFFFFFF; both update on the same edge as the resolve.
- Undefined: both ports tied to 0 and no counter logic is built. Ports exist in both builds.

Test Plan:
- Reset, push pc=0x100 pred=0, resolve ex_taken=0 -> next cycle upd_valid=1, upd_taken=0, mispredict=0, occupancy=0.
- Push pc=0x200 pred=0, resolve ex_taken=1 ex_target=0x300 -> mispredict=1, redirect_pc=0x300, upd_taken=1, occupancy=0.
- Push pc=0x400 pred=1 target=0x500, resolve taken target=0x504 -> mispredict=1, redirect_pc=0x504.
- Push pc=0x600 pred=1 target=0x700, resolve ex_taken=0 -> mispredict=1, redirect_pc=0x604.
- Fill DEPTH=4 entries:
  - fetch_ready=0;
  - push plus correct resolve -> occupancy 3, fetch_ready returns 1 the next cycle;
  - 2 more pushes, then a mispredict on the head -> occupancy 0.
- ex_valid on empty queue -> err_underflow=1 (sticky), upd_valid=0.
- ext_flush with ex_valid and 2 entries -> occupancy 0, upd_valid=0.
- With BRANCH_STATS_EN, after the sequence above: stat_resolved=8, stat_mispredict=4.
